// File: rtl/data_ram_responder.sv
// Byte-masked word RAM slave: one outstanding read with fixed latency, one write per cycle.
// Define DATA_RAM_RANGE_CHECK_EN to flag out-of-range accesses instead of wrapping them.
module data_ram_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_err,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        wr_ready,
  output logic        wr_done,
  output logic        wr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {R_IDLE, R_WAIT} rstate_e;

  rstate_e           state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_ready_q, rd_valid_q, rd_err_q, rd_oor_q;
  logic [31:0]       rd_data_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              wr_ready_q, wr_done_q, wr_err_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [31:0]       rd_off, wr_off;
  logic [IDX_W-1:0]  rd_idx, wr_idx, samp_idx;
  logic              rd_oor, wr_oor, samp_oor;
  logic              rd_acc, wr_acc;
  logic [31:0]       samp_data_d;
  logic              unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign rd_off = rd_addr - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_idx = rd_off[2 +: IDX_W];
  assign wr_idx = wr_off[2 +: IDX_W];
  assign unused_addr_bits = ^{rd_off, wr_off};

`ifdef DATA_RAM_RANGE_CHECK_EN
  assign rd_oor = ({1'b0, rd_off} >= LIMIT);
  assign wr_oor = ({1'b0, wr_off} >= LIMIT);
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  assign rd_acc = rd_req & rd_ready_q;
  assign wr_acc = wr_req & wr_ready_q;

  // Latency 1 samples straight from the request; longer latencies use the latched address.
  assign samp_idx = (state_q == R_IDLE) ? rd_idx : rd_idx_q;
  assign samp_oor = (state_q == R_IDLE) ? rd_oor : rd_oor_q;

  always_comb begin
    samp_data_d = mem_q[samp_idx];
    if (wr_acc && !wr_oor && (wr_idx == samp_idx)) begin
      samp_data_d = merge_bytes(mem_q[samp_idx], wr_data, wr_strb);
    end
    if (samp_oor) samp_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      rd_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      rd_idx_q   <= '0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          rd_ready_q <= 1'b1;
          if (rd_acc) begin
            if (READ_LATENCY == 1) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= samp_data_d;
              rd_err_q   <= samp_oor;
            end else begin
              state_q    <= R_WAIT;
              cnt_q      <= CNT_INIT;
              rd_ready_q <= 1'b0;
              rd_idx_q   <= rd_idx;
              rd_oor_q   <= rd_oor;
            end
          end
        end
        R_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= R_IDLE;
            cnt_q      <= '0;
            rd_ready_q <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_data_q  <= samp_data_d;
            rd_err_q   <= samp_oor;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready_q <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_ready_q <= 1'b1;
      wr_done_q  <= wr_acc;
      wr_err_q   <= wr_acc & wr_oor;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !wr_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_ready = rd_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign wr_ready = wr_ready_q;
  assign wr_done  = wr_done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: instance 0 has latency 3 / 4096 words,
// instance 1 has latency 1 / 16 words; reads are scored through per-instance queues.
module tb_data_ram_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req [2];
  logic [31:0] rd_addr [2];
  logic        rd_ready [2];
  logic        rd_valid [2];
  logic [31:0] rd_data [2];
  logic        rd_err [2];
  logic        wr_req [2];
  logic [31:0] wr_addr [2];
  logic [31:0] wr_data [2];
  logic [3:0]  wr_strb [2];
  logic        wr_ready [2];
  logic        wr_done [2];
  logic        wr_err [2];

  exp_t q [2][$];
  int   checks = 0;
  int   errs = 0;
  int   cyc = 0;
  logic rdp [2];

`ifdef DATA_RAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_responder #(.DEPTH_WORDS(4096), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ready(rd_ready[0]),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_err(rd_err[0]),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_strb(wr_strb[0]),
    .wr_ready(wr_ready[0]), .wr_done(wr_done[0]), .wr_err(wr_err[0])
  );

  data_ram_responder #(.DEPTH_WORDS(16), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ready(rd_ready[1]),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_err(rd_err[1]),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_strb(wr_strb[1]),
    .wr_ready(wr_ready[1]), .wr_done(wr_done[1]), .wr_err(wr_err[1])
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a read, wait (bounded) for accept, optionally queue the expected response.
  task automatic rd_issue(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic e, input bit push);
    int   n = 0;
    logic acc = 1'b0;
    rd_req[i] = 1'b1;
    rd_addr[i] = a;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = rd_ready[i];
      @(posedge clk);
      #1;
      n++;
    end
    rd_req[i] = 1'b0;
    chk1("rd_accept", acc, 1'b1);
    if (acc && push) q[i].push_back('{d, e, cyc + lat(i) - 1});
  endtask

  task automatic rd(input int i, input logic [31:0] a, input logic [31:0] d, input logic e);
    rd_issue(i, a, d, e, 1'b1);
    drain(8);
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic e);
    int   n = 0;
    logic acc = 1'b0;
    wr_req[i] = 1'b1;
    wr_addr[i] = a;
    wr_data[i] = d;
    wr_strb[i] = s;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = wr_ready[i];
      @(posedge clk);
      #1;
      n++;
    end
    wr_req[i] = 1'b0;
    chk1("wr_accept", acc, 1'b1);
    @(negedge clk);
    chk1("wr_done", wr_done[i], 1'b1);
    chk1("wr_err", wr_err[i], e);
    @(negedge clk);
    chk1("wr_done_pulse", wr_done[i], 1'b0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (rd_valid[i]) begin
          exp_t e;
          if (q[i].size() == 0) begin
            chk1("rd_valid_unexpected", rd_valid[i], 1'b0);
          end else begin
            e = q[i].pop_front();
            chk32("rd_data", rd_data[i], e.data);
            chk1("rd_err", rd_err[i], e.err);
            chk32("rd_valid_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  // Master must not withdraw a read request that has not been accepted.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && rdp[i] && !rd_req[i]) begin
        errs++;
        $error("FAIL rd_req_dropped inst=%0d observed=0 expected=1", i);
      end
      rdp[i] <= rst_n & rd_req[i] & ~rd_ready[i];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd_req[i] = 1'b0; rd_addr[i] = '0; wr_req[i] = 1'b0;
      wr_addr[i] = '0; wr_data[i] = '0; wr_strb[i] = '0; rdp[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1("rst_rd_ready", rd_ready[i], 1'b0);
      chk1("rst_wr_ready", wr_ready[i], 1'b0);
      chk1("rst_rd_valid", rd_valid[i], 1'b0);
      chk1("rst_wr_done", wr_done[i], 1'b0);
      chk32("rst_rd_data", rd_data[i], 32'h0);
      chk1("rst_rd_err", rd_err[i], 1'b0);
      chk1("rst_wr_err", wr_err[i], 1'b0);
    end
    rst_n = 1'b1;
    #1;
    chk1("rel_rd_ready_before_edge", rd_ready[0], 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1("rel_rd_ready", rd_ready[i], 1'b1);
      chk1("rel_wr_ready", wr_ready[i], 1'b1);
    end
    @(negedge clk);
    chk1("rel_rd_valid", rd_valid[0], 1'b0);
    chk1("rel_wr_done", wr_done[0], 1'b0);
    @(posedge clk);
    #1;

    // Full write then latency-3 read
    wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(0, 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Single-lane write, then a zero-strobe write that must not change anything
    wr(0, 32'h10, 32'h0000_AA00, 4'b0010, 1'b0);
    rd(0, 32'h10, 32'hDEAD_AAEF, 1'b0);
    wr(0, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd(0, 32'h13, 32'hDEAD_AAEF, 1'b0);

    // Back-to-back latency-1 reads with rd_req held
    wr(1, 32'h0, 32'h1111_1111, 4'hF, 1'b0);
    wr(1, 32'h4, 32'h2222_2222, 4'hF, 1'b0);
    rd_req[1] = 1'b1;
    rd_addr[1] = 32'h0;
    @(negedge clk);
    chk1("b2b_ready0", rd_ready[1], 1'b1);
    @(posedge clk);
    #1;
    q[1].push_back('{32'h1111_1111, 1'b0, cyc});
    rd_addr[1] = 32'h4;
    @(negedge clk);
    chk1("b2b_ready1", rd_ready[1], 1'b1);
    @(posedge clk);
    #1;
    q[1].push_back('{32'h2222_2222, 1'b0, cyc});
    rd_req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("b2b_valid_end", rd_valid[1], 1'b0);
    drain(2);

    // Write lands on the same edge the latency-3 read samples the RAM
    rd_issue(0, 32'h10, 32'h11AD_AAEF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    wr_req[0] = 1'b1;
    wr_addr[0] = 32'h10;
    wr_data[0] = 32'h1100_0000;
    wr_strb[0] = 4'b1000;
    @(posedge clk);
    #1;
    wr_req[0] = 1'b0;
    @(negedge clk);
    chk1("wf_wr_done", wr_done[0], 1'b1);
    drain(4);
    rd(0, 32'h10, 32'h11AD_AAEF, 1'b0);

    // Out-of-range accesses on the 16-word instance
    rd(1, 32'h40, RC ? 32'h0 : 32'h1111_1111, RC);
    wr(1, 32'h44, 32'h5555_5555, 4'hF, RC);
    rd(1, 32'h4, RC ? 32'h2222_2222 : 32'h5555_5555, 1'b0);

    // Reset one cycle after a read accept drops the read
    rd_issue(0, 32'h10, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midrst_rd_ready", rd_ready[0], 1'b0);
    chk32("midrst_rd_data", rd_data[0], 32'h0);
    drain(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("midrst_no_valid", rd_valid[0], 1'b0);
    end
    chk1("midrst_ready_back", rd_ready[0], 1'b1);
    drain(2);

    chk32("q0_empty", 32'(q[0].size()), 32'h0);
    chk32("q1_empty", 32'(q[1].size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
